// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Serialises host words LSB-first onto the tile configuration chain
// (ccff_head -> ... -> ccff_tail), issuing one chain shift per prog_clk
// cycle through prog_clk_en.
// Optional feature macro: CCFF_READBACK_EN adds a VERIFY pass that
// recirculates the chain once and compares ones-counts of what was shifted
// in against what comes back out of ccff_tail.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              tail_err
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WC_W   = $clog2(NWORDS + 1);
    localparam int SC_W   = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  WORDS_MAX = WC_W'(NWORDS);
    localparam logic [SC_W-1:0]  SR_FULL   = SC_W'(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [WORD_W-1:0] buf_q,      buf_d;
    logic              buf_full_q, buf_full_d;
    logic [WORD_W-1:0] sr_q,       sr_d;
    logic [SC_W-1:0]   sr_cnt_q,   sr_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [WC_W-1:0]   words_q,    words_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // A chain shift happens whenever SHIFT holds at least one unsent bit.
    logic shifting;
    logic take;
    logic last_shift;

    assign shifting   = (state_q == ST_SHIFT) && (sr_cnt_q != '0);
    assign word_ready = (state_q == ST_SHIFT) && !buf_full_q && (words_q < WORDS_MAX);
    assign take       = word_valid && word_ready;
    assign last_shift = shifting && (bit_cnt_q == LAST_BIT);
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef CCFF_READBACK_EN
    logic [CNT_W-1:0] ones_sent_q, ones_sent_d;
    logic [CNT_W-1:0] ones_seen_q, ones_seen_d;
    logic             tail_err_q,  tail_err_d;

    // During VERIFY the chain output is fed straight back so the image is restored.
    assign prog_clk_en = shifting || (state_q == ST_VERIFY);
    assign ccff_head   = shifting ? sr_q[0] : ((state_q == ST_VERIFY) ? ccff_tail : 1'b0);
    assign tail_err    = tail_err_q;
`else
    wire unused_tail = ccff_tail;

    assign prog_clk_en = shifting;
    assign ccff_head   = shifting ? sr_q[0] : 1'b0;
    assign tail_err    = 1'b0;
`endif

    // Next-state logic for the FSM, word buffer, shift register and counters.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        words_d    = words_q;
        busy_d     = busy_q;
        done_d     = done_q;
`ifdef CCFF_READBACK_EN
        ones_sent_d = ones_sent_q;
        ones_seen_d = ones_seen_q;
        tail_err_d  = tail_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d    = ST_SHIFT;
                    buf_full_d = 1'b0;
                    sr_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    words_d    = '0;
                    busy_d     = 1'b1;
`ifdef CCFF_READBACK_EN
                    ones_sent_d = '0;
                    ones_seen_d = '0;
                    tail_err_d  = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (shifting) begin
                    sr_d      = sr_q >> 1;
                    sr_cnt_d  = sr_cnt_q - SC_W'(1);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    ones_sent_d = ones_sent_q + CNT_W'(sr_q[0]);
`endif
                end
                // Refill on the edge that empties the shift register: no bubble.
                if ((sr_cnt_q <= SC_W'(1)) && buf_full_q) begin
                    sr_d       = buf_q;
                    sr_cnt_d   = SR_FULL;
                    buf_full_d = 1'b0;
                end
                if (take) begin
                    buf_d      = word_data;
                    buf_full_d = 1'b1;
                    words_d    = words_q + WC_W'(1);
                end
                // Chain is full: padding bits of the final word are dropped.
                if (last_shift) begin
                    sr_cnt_d   = '0;
                    buf_full_d = 1'b0;
                    bit_cnt_d  = '0;
`ifdef CCFF_READBACK_EN
                    state_d    = ST_VERIFY;
`else
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
`endif
                end
            end
`ifdef CCFF_READBACK_EN
            ST_VERIFY: begin
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                ones_seen_d = ones_seen_q + CNT_W'(ccff_tail);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    tail_err_d = (ones_seen_q + CNT_W'(ccff_tail)) != ones_sent_q;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any load immediately.
    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sr_q       <= '0;
            sr_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            words_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
            ones_sent_q <= '0;
            ones_seen_q <= '0;
            tail_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sr_q       <= sr_d;
            sr_cnt_q   <= sr_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            words_q    <= words_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CCFF_READBACK_EN
            ones_sent_q <= ones_sent_d;
            ones_seen_q <= ones_seen_d;
            tail_err_q  <= tail_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader
// Scoreboard bench: each load pushes its expected chain image, accepted-word
// count, shift count and tail_err into a queue; a monitor pops and compares
// on every done pulse. A 20-flop chain model lives on prog_clk & prog_clk_en.
module tb_ccff_bitstream_loader;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int NW = 3;
`ifdef CCFF_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int EXP_SHIFTS = RB ? 2 * CL : CL;

    logic          prog_clk   = 1'b0;
    logic          reset      = 1'b1;
    logic          cfg_start  = 1'b0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word_data  = '0;
    logic          word_ready;
    logic          ccff_head;
    logic          prog_clk_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          tail_err;

    logic [CL-1:0] chain = '0;
    assign ccff_tail = chain[0];

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk   (prog_clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .ccff_head  (ccff_head),
        .prog_clk_en(prog_clk_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .tail_err   (tail_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [CL-1:0] chain;
        int            words;
        int            shifts;
        bit            gapfree;
        bit            terr;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   en_cnt = 0;
    int   acc_cnt = 0;
    int   stall_cnt = 0;
    bit   flipped = 1'b0;
    bit   flip_req = 1'b0;
    int   flip_idx = 0;
    bit   done_prev = 1'b0;

    task automatic check(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Chain model plus per-load event counters, updated on each rising edge.
    always @(posedge prog_clk) begin : chain_model
        logic [CL-1:0] c;
        if (reset) begin
            en_cnt = 0; acc_cnt = 0; stall_cnt = 0; flipped = 1'b0;
        end else if (done) begin
            en_cnt = 0; acc_cnt = 0; stall_cnt = 0; flipped = 1'b0;
        end else begin
            c = chain;
            if (word_valid && word_ready) acc_cnt++;
            if (prog_clk_en) begin
                c = {ccff_head, c[CL-1:1]};
                en_cnt++;
                if (flip_req && !flipped && en_cnt == CL) begin
                    c[flip_idx] = ~c[flip_idx];
                    flipped = 1'b1;
                end
            end else if (busy && en_cnt > 0 && en_cnt < CL) begin
                stall_cnt++;
            end
            chain <= c;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard compare on done.
    always @(negedge prog_clk) begin
        if (!reset) begin
            if (!prog_clk_en) check("head_when_stalled", ccff_head, 0);
            if (!busy) check("ready_when_idle", word_ready, 0);
            if (done) begin
                check("done_single_cycle", done_prev, 0);
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done=1 required no pending load");
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_chain"}, chain, mon_e.chain);
                    check({mon_e.name, "_words"}, acc_cnt, mon_e.words);
                    check({mon_e.name, "_shifts"}, en_cnt, mon_e.shifts);
                    check({mon_e.name, "_tail_err"}, tail_err, mon_e.terr);
                    if (mon_e.gapfree) check({mon_e.name, "_stalls"}, stall_cnt, 0);
                    $display("[TB] load %s done: chain=%05h words=%0d shifts=%0d tail_err=%0d",
                             mon_e.name, chain, acc_cnt, en_cnt, tail_err);
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic start_load();
        cfg_start = 1'b1;
        @(negedge prog_clk);
        cfg_start = 1'b0;
        check("tail_err_cleared", tail_err, 0);
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            word_valid = 1'b0;
            repeat (gap) @(negedge prog_clk);
        end
        word_valid = 1'b1;
        word_data  = w;
        while (!word_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL word_accept_timeout: got word_ready=0 for 200 cycles required 1");
        end
        @(negedge prog_clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 300) begin
            tests++; fails++;
            $display("FAIL done_timeout: got done=0 for 300 cycles required 1");
        end
        @(negedge prog_clk);
    endtask

    task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input int g0, input int g1,
                            input int g2, input bit extra, input bit restart,
                            input bit flip, input string nm);
        exp_t          e;
        logic [23:0]   v;
        logic [CL-1:0] m;
        m = '0;
        flip_idx = int'($urandom_range(CL - 1));
        if (flip) m[flip_idx] = 1'b1;
        v = {w2, w1, w0};
        e.chain   = v[CL-1:0] ^ m;
        e.words   = NW;
        e.shifts  = EXP_SHIFTS;
        e.gapfree = (g1 == 0) && (g2 == 0);
        e.terr    = RB && flip;
        e.name    = nm;
        flip_req  = flip;
        start_load();
        sb.push_back(e);
        send_word(w0, g0);
        if (restart) begin
            fork
                begin
                    cfg_start = 1'b1;
                    @(negedge prog_clk);
                    cfg_start = 1'b0;
                end
            join_none
        end
        send_word(w1, g1);
        send_word(w2, g2);
        if (extra) word_data = WW'($urandom);
        else word_valid = 1'b0;
        wait_done();
        word_valid = 1'b0;
        repeat (3) @(negedge prog_clk);
        check({nm, "_tail_err_held"}, tail_err, e.terr);
        check({nm, "_idle_after_done"}, busy, 0);
        flip_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        repeat (2) @(negedge prog_clk);
        check("rst_word_ready", word_ready, 0);
        check("rst_ccff_head", ccff_head, 0);
        check("rst_prog_clk_en", prog_clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tail_err", tail_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge prog_clk);

        // Valid held high, gap-free.
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b0, 1'b0, 1'b0, "t1_held");
        // Host drops valid for 5 cycles after the first word.
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 5, 0, 1'b0, 1'b0, 1'b0, "t2_gap5");

        // Reset after 9 shifts aborts the load.
        start_load();
        send_word(8'hA5, 0);
        word_data = 8'h3C;
        n = 0;
        while (en_cnt < 9 && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        check("t3_reached_9_shifts", en_cnt, 9);
        #2 reset = 1'b1;
        #1;
        check("t3_rst_word_ready", word_ready, 0);
        check("t3_rst_ccff_head", ccff_head, 0);
        check("t3_rst_prog_clk_en", prog_clk_en, 0);
        check("t3_rst_busy", busy, 0);
        check("t3_rst_done", done, 0);
        check("t3_rst_tail_err", tail_err, 0);
        word_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        reset = 1'b0;
        @(negedge prog_clk);
        run_load(8'h5A, 8'hC3, 8'hF0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "t3_reload");

        // cfg_start pulsed mid-load, 4th word offered after the third.
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b1, 1'b1, 1'b0, "t4_restart");

        // Clean readback, then one chain flop corrupted before VERIFY.
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b0, 1'b0, 1'b0, "t5_clean");
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b0, 1'b0, 1'b1, "t6_flip");
        run_load(8'h11, 8'h22, 8'h33, 0, 0, 0, 1'b0, 1'b0, 1'b0, "t6_after");

        // Randomised words, gaps (some long enough to underrun) and options.
        for (int i = 0; i < 8; i++) begin
            run_load(WW'($urandom), WW'($urandom), WW'($urandom),
                     int'($urandom_range(4)), int'($urandom_range(14)),
                     int'($urandom_range(14)), 1'($urandom), 1'($urandom),
                     1'($urandom), $sformatf("rnd%0d", i));
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
